// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   div_state_t    : FSM encoding (IDLE, RUN, DONE)
//   DEF_DIVIDEND_W : default dividend / quotient width
//   DEF_DIVISOR_W  : default divisor / remainder width
//   CNT_W          : step-counter width for the default dividend width
//   cnt_w()        : step-counter width for any dividend width
package div_pkg;

    localparam int DEF_DIVIDEND_W = 16;
    localparam int DEF_DIVISOR_W  = 8;

    function automatic int cnt_w(input int dividend_w);
        return $clog2(dividend_w);
    endfunction

    localparam int CNT_W = cnt_w(DEF_DIVIDEND_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
//   pr_in   : partial remainder before the step (DIVISOR_W+1 bits)
//   bit_in  : next dividend bit, shifted in at the LSB
//   divisor : divisor operand
//   pr_out  : partial remainder after the step
//   q_bit   : quotient bit produced by this step
module div_step #(
    parameter int DIVISOR_W = 8
) (
    input  logic [DIVISOR_W:0]   pr_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   pr_out,
    output logic                 q_bit
);

    logic [DIVISOR_W:0] pr_shift;
    // Between steps the partial remainder is always below the divisor, so its
    // top bit is zero and drops out of the shift.
    logic               unused_pr_msb;

    assign unused_pr_msb = pr_in[DIVISOR_W];

    always_comb begin
        pr_shift = {pr_in[DIVISOR_W-1:0], bit_in};
        // Compare at DIVISOR_W+1 bits so a shifted value above the divisor
        // range is not lost.
        q_bit    = (pr_shift >= {1'b0, divisor});
        pr_out   = q_bit ? (pr_shift - {1'b0, divisor}) : pr_shift;
    end

endmodule

// File: rtl/seq_div_16by8.sv
// Multi-cycle unsigned restoring divider with start/busy/done handshake.
// One quotient bit per clock, MSB first; divide-by-zero completes in one cycle.
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset (aborts any operation)
//   start     : request, sampled only in IDLE
//   dividend  : numerator, captured on accepted start
//   divisor   : denominator, captured on accepted start
//   busy      : high in RUN and DONE
//   done      : one-cycle pulse, results valid
//   quotient  : unsigned quotient (all ones on divide-by-zero)
//   remainder : unsigned remainder (zero on divide-by-zero)
//   dbz       : divide-by-zero flag of the last completed operation
// DIVISOR_W must not exceed DIVIDEND_W.
module seq_div_16by8
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  dbz
);

    localparam int            CW       = cnt_w(DIVIDEND_W);
    localparam logic [CW-1:0] LAST_CNT = CW'(DIVIDEND_W - 1);

    div_state_t            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    // Dividend shift register: dividend bits leave at the MSB while quotient
    // bits enter at the LSB, so after the last step it holds the quotient.
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [DIVISOR_W:0]    pr_q, pr_d;
    logic [DIVIDEND_W-1:0] quot_q, quot_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic                  dbz_q, dbz_d;

    logic [DIVISOR_W:0]    step_pr;
    logic                  step_q;

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .pr_in   (pr_q),
        .bit_in  (dvd_q[DIVIDEND_W-1]),
        .divisor (dvs_q),
        .pr_out  (step_pr),
        .q_bit   (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        pr_d    = pr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        dvd_d   = dividend;
                        dvs_d   = divisor;
                        pr_d    = '0;
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        quot_d  = '1;
                        rem_d   = '0;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                pr_d  = step_pr;
                dvd_d = {dvd_q[DIVIDEND_W-2:0], step_q};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    quot_d  = {dvd_q[DIVIDEND_W-2:0], step_q};
                    rem_d   = step_pr[DIVISOR_W-1:0];
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            pr_q    <= pr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_div_16by8.sv
// Directed self-checking bench for seq_div_16by8.
module tb_seq_div_16by8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        dbz;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_div_16by8 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue a one-cycle start and follow the operation to its done pulse.
    task automatic run_div(input string tag, input logic [15:0] a, input logic [7:0] b,
                           input logic [15:0] eq, input logic [7:0] er,
                           input logic edbz, input int elat);
        int n;
        int nbusy;
        bit seen;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        nbusy = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (busy) nbusy++;
            if (done) seen = 1;
        end
        chk({tag, "_lat"}, n, elat);
        chk({tag, "_busy_cyc"}, nbusy, elat);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dbz"}, dbz, edbz);
        @(negedge clk);
        chk({tag, "_done_off"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_q_hold"}, quotient, eq);
    endtask

    initial begin
        int pulses;
        int last;
        int n;
        bit stable;
        bit seen;
        logic [15:0] q_at;
        logic [7:0]  r_at;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dbz", dbz, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_div("d1000_7", 16'd1000, 8'd7, 16'h008E, 8'd6, 1'b0, 17);
        run_div("dffff_ff", 16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 17);
        run_div("d5_9", 16'd5, 8'd9, 16'd0, 8'd5, 1'b0, 17);
        run_div("d0_3", 16'd0, 8'd3, 16'd0, 8'd0, 1'b0, 17);
        run_div("dbz1234", 16'd1234, 8'd0, 16'hFFFF, 8'd0, 1'b1, 1);
        run_div("d10_3", 16'd10, 8'd3, 16'd3, 8'd1, 1'b0, 17);

        // Second start during RUN must be ignored.
        @(negedge clk);
        dividend = 16'd200;
        divisor  = 8'd9;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        dividend = 16'd50;
        divisor  = 8'd2;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        pulses = 0;
        q_at = '0;
        r_at = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                q_at = quotient;
                r_at = remainder;
            end
        end
        chk("busy_start_pulses", pulses, 1);
        chk("busy_start_q", q_at, 16'd22);
        chk("busy_start_r", r_at, 8'd2);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        dividend = 16'd500;
        divisor  = 8'd5;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_q", quotient, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("arst_no_done", pulses, 0);
        run_div("d100_10", 16'd100, 8'd10, 16'd10, 8'd0, 1'b0, 17);

        // Start held high: one result every 18 cycles.
        @(negedge clk);
        dividend = 16'd300;
        divisor  = 8'd7;
        start    = 1'b1;
        pulses = 0;
        last   = -1;
        stable = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                chk("hold_q", quotient, 16'd42);
                chk("hold_r", remainder, 8'd6);
                if (last >= 0) chk("hold_period", i - last, 18);
                last = i;
                pulses++;
            end else if (pulses > 0 && (quotient != 16'd42 || remainder != 8'd6)) begin
                stable = 1'b0;
            end
        end
        start = 1'b0;
        chk("hold_pulses", pulses, 3);
        chk("hold_stable", stable, 1);
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (!busy) seen = 1;
        end
        chk("hold_drain", seen, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_div_16by8.md
Name: seq_div_16by8

Overview:
- Multi-cycle restoring divider; the inverse companion to the existing combinational 8x8 multiplier path.
- Takes a 16-bit dividend and an 8-bit divisor. Produces a 16-bit quotient and an 8-bit remainder using a start/busy/done handshake.
- Sits beside the multiplier in the FPGA top level. Operands come from the switches; the quotient and remainder drive seven-segment digits.

Parameters:
- DIVIDEND_W, 16, dividend and quotient width.
- DIVISOR_W, 8, divisor and remainder width (must be ≤ DIVIDEND_W).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- dividend  input  DIVIDEND_W  numerator, captured on accepted start.
- divisor  input  DIVISOR_W  denominator, captured on accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  single-cycle pulse; results valid.
- quotient  output  DIVIDEND_W  unsigned quotient.
- remainder  output  DIVISOR_W  unsigned remainder.
- dbz  output  1  divide-by-zero flag for the last completed operation.

Behaviour:
- Reset is asynchronous and active-high. While rst is high: state = IDLE; busy, done, dbz = 0; quotient and remainder = 0; internal registers cleared.
- Assertion mid-operation aborts immediately. No result is produced.
- FSM states are IDLE, RUN and DONE.
- IDLE, start=1, divisor≠0, at edge k:
  - Latch the dividend into the shift register and the divisor into a register.
  - Clear the partial remainder (DIVISOR_W+1 bits).
  - Clear the step counter and go to RUN.
- IDLE, start=1, divisor=0, at edge k:
  - Go directly to DONE.
  - At that same edge, load quotient = all ones, remainder = 0, dbz = 1.
- RUN performs one restoring step per cycle, MSB first:
  - Compute pr' = {pr[DIVISOR_W-1:0], next dividend bit}.
  - If pr' ≥ divisor: pr = pr' − divisor and the quotient bit = 1. Otherwise pr = pr' and the quotient bit = 0.
  - The quotient bits shift into the dividend register as it empties.
- The counter runs 0..DIVIDEND_W-1. On the edge that completes step DIVIDEND_W-1:
  - Go to DONE.
  - Load quotient and remainder from the final values.
  - Set dbz = 0.
- DONE lasts exactly one cycle with done=1, busy=1, then returns to IDLE unconditionally.
- Latency, measured from the start edge k:
  - Normal division: done is high during the cycle after edge k+DIVIDEND_W (17 cycles for defaults).
  - Divide-by-zero: done is high during the cycle after edge k.
- Output hold: quotient, remainder and dbz change only on entry to DONE or on reset. They hold through the following IDLE and RUN periods.
- start is ignored while busy=1, including the DONE cycle. Operand changes during RUN have no effect.
- A start held continuously is accepted again in the first IDLE cycle after DONE. Back-to-back throughput is one result per DIVIDEND_W+2 cycles.
- All arithmetic is unsigned. The remainder is always < divisor when dbz=0. The compare uses the DIVISOR_W+1-bit partial remainder so no overflow is lost.

Decomposition:
- Package div_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE);
  - default width localparams;
  - the counter-width constant $clog2(DIVIDEND_W).
- One natural sub-module, div_step: a purely combinational single restoring step.
  - Inputs: partial remainder, incoming bit, divisor.
  - Outputs: next partial remainder, quotient bit.
- The top-level divider holds the FSM, counter and registers.

Test Plan:
- 1000 / 7: start for one cycle → done exactly 17 cycles after the start edge; quotient=0x008E (142), remainder=6, dbz=0; busy high for 17 cycles.
- 0xFFFF / 0xFF → quotient=0x0101, remainder=0x00. Also 5 / 9 → quotient=0, remainder=5. Also 0 / 3 → quotient=0, remainder=0.
- 1234 / 0 → done one cycle after the start edge; quotient=0xFFFF, remainder=0, dbz=1. A following 10 / 3 yields quotient=3, remainder=1, dbz=0.
- Start 200 / 9. During RUN cycle 5, pulse start with operands 50 / 2 → the second start is ignored; the result is quotient=22, remainder=2, and only one done pulse occurs.
- Assert rst asynchronously mid-RUN (no clock edge) → busy, done and quotient drop to 0 immediately. After release, no done pulse appears until a new start. A new 100 / 10 gives quotient=10, remainder=0.
- Hold start=1 continuously with 300 / 7 → done pulses every 18 cycles, each giving quotient=42, remainder=6. Outputs are stable between pulses.
